// File: rtl/regfile_write.sv
// 32 x 32-bit register file write side with a sequential clear engine.
// Writes land on the accepting edge; a clear takes exactly 32 cycles.
// Ready drops while a clear runs; a pending write must be held until Ready returns.
module regfile_write #(
  parameter int unsigned ZERO_R0 = 1,
  parameter logic [31:0] CLR_VAL = 32'h0
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        We,
  input  logic [4:0]  Wn,
  input  logic [31:0] D,
  output logic        Ready,
  input  logic        Clr,
  output logic        Busy,
  output logic [31:0] Q0,
  output logic [31:0] Q1,
  output logic [31:0] Q2,
  output logic [31:0] Q3,
  output logic [31:0] Q4,
  output logic [31:0] Q5,
  output logic [31:0] Q6,
  output logic [31:0] Q7,
  output logic [31:0] Q8,
  output logic [31:0] Q9,
  output logic [31:0] Q10,
  output logic [31:0] Q11,
  output logic [31:0] Q12,
  output logic [31:0] Q13,
  output logic [31:0] Q14,
  output logic [31:0] Q15,
  output logic [31:0] Q16,
  output logic [31:0] Q17,
  output logic [31:0] Q18,
  output logic [31:0] Q19,
  output logic [31:0] Q20,
  output logic [31:0] Q21,
  output logic [31:0] Q22,
  output logic [31:0] Q23,
  output logic [31:0] Q24,
  output logic [31:0] Q25,
  output logic [31:0] Q26,
  output logic [31:0] Q27,
  output logic [31:0] Q28,
  output logic [31:0] Q29,
  output logic [31:0] Q30,
  output logic [31:0] Q31
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  logic [4:0]  cnt_nxt;
  logic        wr_acc;
  logic [31:0] wr_dec;
  logic [31:0] clr_dec;
  wire  [31:0] q [32];

  // Busy is the registered CLEAR state; writes are refused while it is high.
  assign Busy   = (state == CLEAR);
  assign Ready  = ~Busy;
  assign wr_acc = We & Ready;

  // One-hot decoders; Wn is only looked at when a write is actually accepted.
  assign wr_dec  = wr_acc ? (32'd1 << Wn) : 32'd0;
  assign clr_dec = Busy ? (32'd1 << cnt) : 32'd0;

  // State and sweep counter; reset aborts any clear in progress.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: Clr only matters in IDLE, so a clear can never restart or stretch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (Clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = 5'd0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + 5'd1;
        if (cnt == 5'd31) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 5'd0;
      end
    endcase
  end

  for (genvar i = 0; i < 32; i++) begin : g_reg
    if (ZERO_R0 != 0 && i == 0) begin : g_zero
      // Register 0 has no storage; its decoder bits are simply dropped.
      logic unused_dec0;
      assign unused_dec0 = wr_dec[i] ^ clr_dec[i];
      assign q[i] = 32'd0;
    end else begin : g_rw
      logic [31:0] r;
      // Clear and write never coincide because writes need Ready, but clear wins anyway.
      always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
          r <= 32'd0;
        end else if (clr_dec[i]) begin
          r <= CLR_VAL;
        end else if (wr_dec[i]) begin
          r <= D;
        end
      end
      assign q[i] = r;
    end
  end

  assign Q0  = q[0];
  assign Q1  = q[1];
  assign Q2  = q[2];
  assign Q3  = q[3];
  assign Q4  = q[4];
  assign Q5  = q[5];
  assign Q6  = q[6];
  assign Q7  = q[7];
  assign Q8  = q[8];
  assign Q9  = q[9];
  assign Q10 = q[10];
  assign Q11 = q[11];
  assign Q12 = q[12];
  assign Q13 = q[13];
  assign Q14 = q[14];
  assign Q15 = q[15];
  assign Q16 = q[16];
  assign Q17 = q[17];
  assign Q18 = q[18];
  assign Q19 = q[19];
  assign Q20 = q[20];
  assign Q21 = q[21];
  assign Q22 = q[22];
  assign Q23 = q[23];
  assign Q24 = q[24];
  assign Q25 = q[25];
  assign Q26 = q[26];
  assign Q27 = q[27];
  assign Q28 = q[28];
  assign Q29 = q[29];
  assign Q30 = q[30];
  assign Q31 = q[31];

endmodule

// File: doc/regfile_write.md
REGFILE_WRITE -- requirements
Module: regfile_write

Interface
REQ-001 Parameter ZERO_R0, default 1: when 1, register 0 is hardwired to zero and writes to it are discarded.
REQ-002 Parameter CLR_VAL, default 32'h0: the value written to every register by the clear sequence.
REQ-003 Clk  input  1  single clock for the block; all state updates occur on the rising edge.
REQ-004 Clrn  input  1  reset, asynchronous and active-low.
REQ-005 We  input  1  write request valid.
REQ-006 Wn  input  5  destination register number.
REQ-007 D  input  32  write data.
REQ-008 Ready  output  1  write port can accept a request this cycle.
REQ-009 Clr  input  1  start the sequential clear of all registers.
REQ-010 Busy  output  1  clear sequence in progress.
REQ-011 Q0..Q31  output  32 each  current register contents; these ports feed the 32:1 read-port selectors directly.

Function
REQ-012 Storage: 32 registers x 32 bits, with a 5-to-32 one-hot write decoder derived from Wn.
REQ-013 Ready is combinational and equals ~Busy.
REQ-014 Write handshake: a write is accepted on a rising edge where We=1 and Ready=1, and reg[Wn] takes D at that edge.
REQ-015 With ZERO_R0=1, a write to Wn=0 is accepted (handshake completes) but does not change storage, and Q0 is constant 0.
REQ-016 With ZERO_R0=0, register 0 is an ordinary writable register.
REQ-017 Write latency: new data appears on Qn immediately after the accepting edge; there is no write-to-read bypass within the same cycle.
REQ-018 At most one register changes per edge due to a write, and all other registers hold their values.
REQ-019 FSM states are IDLE and CLEAR, with a 5-bit counter Cnt.
REQ-020 IDLE -> CLEAR on an edge where Clr=1; at that edge Cnt<=0 and Busy<=1.
REQ-021 In CLEAR, each edge writes reg[Cnt]<=CLR_VAL (reg 0 is skipped when ZERO_R0=1) and then Cnt<=Cnt+1.
REQ-022 CLEAR -> IDLE on the edge that clears Cnt=31; at that edge Busy<=0 and Cnt wraps to 0.
REQ-023 Busy is high for exactly 32 cycles per clear.
REQ-024 Clr asserted while in CLEAR is ignored: no restart and no extension.
REQ-025 A We asserted while Busy=1 is not accepted, storage is unchanged, and the requester must hold the request until Ready=1.
REQ-026 If Clr=1 and We=1 occur together in IDLE, the write commits at that edge and CLEAR starts; the clear later overwrites that register.
REQ-027 Clr held continuously high causes back-to-back clears, with one IDLE cycle between them.
REQ-028 X or unknown values on Wn are not required to be handled when We=0.

Reset
REQ-029 Clrn=0 asynchronously sets all registers to 0, state to IDLE, Cnt to 0, Busy to 0, and Ready to 1, regardless of the clock.
REQ-030 Reset asserted during CLEAR aborts the sequence, leaving all registers at 0 and the block in IDLE.
REQ-031 Reset deassertion is synchronised externally; the first accepted write occurs on the first rising edge with Clrn=1.

Verification
REQ-032 Reset, then write Wn=5, D=32'hDEADBEEF with We=1 for one cycle -> Q5=32'hDEADBEEF on the next cycle, Ready=1, and all other Qn=0.
REQ-033 With ZERO_R0=1, write Wn=0, D=32'hFFFFFFFF -> Q0 stays 0 and Ready stays 1.
REQ-034 Fill all 32 registers with value n+1, pulse Clr for one cycle -> Busy=1 for exactly 32 cycles; Qn becomes CLR_VAL at edge n+1 after the Clr edge (Q0 stays 0 throughout with ZERO_R0=1); Busy=0 afterwards.
REQ-035 Clr and We (Wn=31, D=32'h1234) asserted together -> Q31=32'h1234 after the first edge, then Q31=0 at the 32nd clear edge.
REQ-036 Hold We=1 (Wn=7, D=32'hA5A5A5A5) during CLEAR -> Ready=0 and Q7 unchanged until Busy falls, then Q7=32'hA5A5A5A5 one edge later.
REQ-037 Assert Clrn=0 mid-clear at Cnt=10 -> all Qn=0 and Busy=0 immediately without a clock edge; the next Clr starts a fresh clear from Cnt=0.
